stack_unit: RTL and testbench
=============================

STACK_UNIT -- requirements
Module: stack_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 16, stack word and PC width.
REQ-002 SHALL have parameter ADDR_W, default 16, stack pointer and address bus width.
REQ-003 SHALL have parameter SP_RESET, default 'h07FF, the empty-stack SP value and top slot address.
REQ-004 SHALL have parameter SP_LIMIT, default 'h0700, the lowest writable slot; 1 <= SP_LIMIT <= SP_RESET; depth = SP_RESET-SP_LIMIT+1.
REQ-005 SHALL have one clock and an asynchronous, active-high reset, as listed in REQ-006 and REQ-007.
REQ-006 SHALL have port clk, input, 1, clock; all state changes on its rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port op_valid, input, 1, operation request.
REQ-009 SHALL have port op, input, 2, operation code: 00 PUSH, 01 POP, 10 CALL, 11 RET.
REQ-010 SHALL have port op_ready, output, 1, unit can accept an operation.
REQ-011 SHALL have port push_data, input, DATA_W, PUSH operand.
REQ-012 SHALL have port pc_in, input, DATA_W, return address pushed by CALL.
REQ-013 SHALL have port call_target, input, DATA_W, CALL destination.
REQ-014 SHALL have port sp_load, input, 1, load SP from sp_in.
REQ-015 SHALL have port sp_in, input, ADDR_W, new SP value.
REQ-016 SHALL have port address_bus, output, ADDR_W, memory address.
REQ-017 SHALL have port data_out, output, DATA_W, memory write data.
REQ-018 SHALL have port data_in, input, DATA_W, memory read data.
REQ-019 SHALL have ports r and w, output, 1 each, read and write strobes.
REQ-020 SHALL have port bus_ready, input, 1, memory completes the access this cycle; low inserts wait states.
REQ-021 SHALL have ports done, fault and pc_load, output, 1 each, completion, error and PC-update strobes.
REQ-022 SHALL have ports pop_data and pc_out, output, DATA_W each, POP result and new PC.
REQ-023 SHALL have port sp, output, ADDR_W, current stack pointer.

Function
REQ-024 SHALL be an FSM with states IDLE, ACCESS and RESP: IDLE->ACCESS on accept; IDLE->RESP on fault; ACCESS->RESP on bus_ready=1; ACCESS holds while bus_ready=0; RESP->IDLE unconditionally.
REQ-025 SHALL drive op_ready = (state==IDLE) && !sp_load; accept when op_valid && op_ready at a rising edge, latching op and operands.
REQ-026 SHALL give sp_load priority in IDLE: sp <= sp_in, no operation accepted; sp_load SHALL be ignored in ACCESS and RESP.
REQ-027 PUSH/CALL in ACCESS: address_bus=sp, w=1, data_out = push_data or pc_in; on the bus_ready edge sp <= sp-1.
REQ-028 POP/RET in ACCESS: address_bus=sp+1, r=1; on the bus_ready edge sp <= sp+1 and data_in is captured.
REQ-029 SHALL assert r or w only in ACCESS, never both, held stable across wait states.
REQ-030 RESP SHALL assert done for exactly one cycle; POP: pop_data = captured word; CALL: pc_load=1, pc_out=call_target; RET: pc_load=1, pc_out=captured word.
REQ-031 Minimum latency is accept edge -> done high 2 cycles later, plus one cycle per bus_ready=0 cycle.
REQ-032 SP arithmetic SHALL be modulo 2^ADDR_W; pop_data/pc_out SHALL hold their last value until the next RESP update.

Reset
REQ-033 On reset: state=IDLE, sp=SP_RESET, r=w=done=fault=pc_load=0, pop_data=pc_out=data_out=0, address_bus=0; any in-flight access is abandoned with no SP change.

Configuration
REQ-034 With STACK_UNIT_BOUNDS_EN defined: PUSH/CALL when sp==SP_LIMIT-1 (full) or POP/RET when sp==SP_RESET (empty) SHALL skip ACCESS, leave sp unchanged, and assert fault and done together in RESP, with pc_load=0.
REQ-035 Without STACK_UNIT_BOUNDS_EN: no checks; fault is tied 0; SP wraps per REQ-032.

Verification
REQ-036 After reset, PUSH 'hBEEF with bus_ready=1 -> write at 'h07FF, sp='h07FE, done 2 cycles after accept.
REQ-037 POP with bus_ready low for 3 cycles, data_in='hBEEF -> r held 4 cycles at 'h07FF, pop_data='hBEEF, sp='h07FF.
REQ-038 CALL with pc_in='h0123 and call_target='h4000, then RET returning 'h0123 -> first pc_out='h4000 with pc_load=1, then pc_out='h0123, sp back to 'h07FF.
REQ-039 With BOUNDS_EN: POP on empty stack -> fault=done=1, r never asserted, sp='h07FF; 256 pushes then PUSH -> fault, no write.
REQ-040 Reset asserted mid-ACCESS during wait states -> r=w=0 immediately, sp='h07FF, op_ready=1 after release.
REQ-041 sp_load=1 with sp_in='h0750 and op_valid=1 in the same cycle -> sp='h0750, operation accepted the next cycle.

Source files
------------

// File: rtl/stack_unit.sv
// Hardware stack engine: PUSH/POP/CALL/RET against an external memory bus with wait states.
// Define STACK_UNIT_BOUNDS_EN to enable full/empty fault detection; otherwise SP wraps freely.
module stack_unit #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned SP_RESET = 'h07FF,
    parameter int unsigned SP_LIMIT = 'h0700
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    input  logic [1:0]        op,
    output logic              op_ready,
    input  logic [DATA_W-1:0] push_data,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] call_target,
    input  logic              sp_load,
    input  logic [ADDR_W-1:0] sp_in,
    output logic [ADDR_W-1:0] address_bus,
    output logic [DATA_W-1:0] data_out,
    input  logic [DATA_W-1:0] data_in,
    output logic              r,
    output logic              w,
    input  logic              bus_ready,
    output logic              done,
    output logic              fault,
    output logic              pc_load,
    output logic [DATA_W-1:0] pop_data,
    output logic [DATA_W-1:0] pc_out,
    output logic [ADDR_W-1:0] sp
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic [1:0] {OP_PUSH = 2'b00, OP_POP = 2'b01, OP_CALL = 2'b10, OP_RET = 2'b11} op_t;

    localparam logic [ADDR_W-1:0] SP_EMPTY = ADDR_W'(SP_RESET);
`ifdef STACK_UNIT_BOUNDS_EN
    localparam logic [ADDR_W-1:0] SP_FULL = ADDR_W'(SP_LIMIT - 1);
`endif

    state_t            state_q, state_d;
    op_t               op_q, op_d;
    op_t               op_in;
    logic [ADDR_W-1:0] sp_q, sp_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] target_q, target_d;
    logic [DATA_W-1:0] pop_data_q, pop_data_d;
    logic [DATA_W-1:0] pc_out_q, pc_out_d;
    logic              resp_fault;
    logic              op_q_writes;
    logic              op_in_writes;

`ifdef STACK_UNIT_BOUNDS_EN
    logic fault_q, fault_d;
    assign resp_fault = fault_q;
`else
    assign resp_fault = 1'b0;
`endif

    assign op_in        = op_t'(op);
    assign op_q_writes  = (op_q == OP_PUSH) || (op_q == OP_CALL);
    assign op_in_writes = (op_in == OP_PUSH) || (op_in == OP_CALL);

    assign op_ready = (state_q == IDLE) && !sp_load;
    assign pop_data = pop_data_q;
    assign pc_out   = pc_out_q;
    assign sp       = sp_q;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        sp_d        = sp_q;
        wdata_d     = wdata_q;
        target_d    = target_q;
        pop_data_d  = pop_data_q;
        pc_out_d    = pc_out_q;
`ifdef STACK_UNIT_BOUNDS_EN
        fault_d     = fault_q;
`endif
        address_bus = '0;
        data_out    = '0;
        r           = 1'b0;
        w           = 1'b0;
        done        = 1'b0;
        fault       = 1'b0;
        pc_load     = 1'b0;

        case (state_q)
            IDLE: begin
                if (sp_load) begin
                    sp_d = sp_in;
                end else if (op_valid) begin
                    op_d     = op_in;
                    wdata_d  = (op_in == OP_PUSH) ? push_data : pc_in;
                    target_d = call_target;
                    state_d  = ACCESS;
`ifdef STACK_UNIT_BOUNDS_EN
                    fault_d = op_in_writes ? (sp_q == SP_FULL) : (sp_q == SP_EMPTY);
                    if (fault_d) state_d = RESP;
`endif
                end
            end
            ACCESS: begin
                // Writes target the free slot at sp; reads fetch the occupied slot above it.
                if (op_q_writes) begin
                    address_bus = sp_q;
                    data_out    = wdata_q;
                    w           = 1'b1;
                end else begin
                    address_bus = sp_q + ADDR_W'(1);
                    r           = 1'b1;
                end
                if (bus_ready) begin
                    state_d = RESP;
                    sp_d    = op_q_writes ? sp_q - ADDR_W'(1) : sp_q + ADDR_W'(1);
                    case (op_q)
                        OP_POP:  pop_data_d = data_in;
                        OP_RET:  pc_out_d   = data_in;
                        OP_CALL: pc_out_d   = target_q;
                        default: ;
                    endcase
                end
            end
            RESP: begin
                done    = 1'b1;
                fault   = resp_fault;
                pc_load = !resp_fault && ((op_q == OP_CALL) || (op_q == OP_RET));
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            op_q       <= OP_PUSH;
            sp_q       <= SP_EMPTY;
            wdata_q    <= '0;
            target_q   <= '0;
            pop_data_q <= '0;
            pc_out_q   <= '0;
`ifdef STACK_UNIT_BOUNDS_EN
            fault_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            sp_q       <= sp_d;
            wdata_q    <= wdata_d;
            target_q   <= target_d;
            pop_data_q <= pop_data_d;
            pc_out_q   <= pc_out_d;
`ifdef STACK_UNIT_BOUNDS_EN
            fault_q    <= fault_d;
`endif
        end
    end

endmodule

// File: tb/tb_stack_unit.sv
// Self-checking bench for stack_unit: behavioural stack model plus a simple memory responder.
// Bounds checks are exercised when STACK_UNIT_BOUNDS_EN is defined; wrap-around otherwise.
module tb_stack_unit;

    localparam int SP_RESET = 'h07FF;
    localparam int SP_LIMIT = 'h0700;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        op_valid = 1'b0;
    logic [1:0]  op = 2'b00;
    logic        op_ready;
    logic [15:0] push_data = '0;
    logic [15:0] pc_in = '0;
    logic [15:0] call_target = '0;
    logic        sp_load = 1'b0;
    logic [15:0] sp_in = '0;
    logic [15:0] address_bus;
    logic [15:0] data_out;
    logic [15:0] data_in;
    logic        r, w;
    logic        bus_ready = 1'b1;
    logic        done, fault, pc_load;
    logic [15:0] pop_data, pc_out, sp;

    logic [15:0] mem     [0:65535];
    logic [15:0] exp_mem [0:65535];
    int          sp_m;
    logic [15:0] exp_pop, exp_pc;
    int          n_chk = 0;
    int          n_fail = 0;

    assign data_in = mem[address_bus];

    always #5 clk = ~clk;

    stack_unit #(
        .DATA_W  (16),
        .ADDR_W  (16),
        .SP_RESET(SP_RESET),
        .SP_LIMIT(SP_LIMIT)
    ) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .op_ready(op_ready),
        .push_data(push_data), .pc_in(pc_in), .call_target(call_target),
        .sp_load(sp_load), .sp_in(sp_in), .address_bus(address_bus), .data_out(data_out),
        .data_in(data_in), .r(r), .w(w), .bus_ready(bus_ready), .done(done), .fault(fault),
        .pc_load(pc_load), .pop_data(pop_data), .pc_out(pc_out), .sp(sp)
    );

    // One complete operation: o = 00 PUSH, 01 POP, 10 CALL, 11 RET; val is the pushed word.
    task automatic run_op(input logic [1:0] o, input logic [15:0] val, input logic [15:0] tgt,
                          input int nwait, input bit noise);
        bit          wr, fe, seen;
        int          addr_e, n, acc;
        logic [15:0] rv;
        wr = (o == 2'b00) || (o == 2'b10);
        fe = 1'b0;
`ifdef STACK_UNIT_BOUNDS_EN
        fe = wr ? (sp_m == SP_LIMIT - 1) : (sp_m == SP_RESET);
`endif
        addr_e = wr ? sp_m : (sp_m + 1) % 65536;
        @(negedge clk);
        op_valid    = 1'b1;
        op          = o;
        push_data   = (o == 2'b00) ? val : 16'($urandom);
        pc_in       = (o == 2'b10) ? val : 16'($urandom);
        call_target = tgt;
        bus_ready   = (nwait == 0);
        sp_load     = 1'b0;
        n_chk++;
        if (op_ready !== 1'b1) begin
            n_fail++; $display("FAIL op_ready_idle: got %b expected 1", op_ready);
        end
        @(posedge clk);
        #1;
        op_valid    = 1'b0;
        op          = 2'($urandom);
        push_data   = 16'($urandom);
        pc_in       = 16'($urandom);
        call_target = 16'($urandom);
        n = 0; acc = 0; seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (done) begin
                seen    = 1'b1;
                sp_load = 1'b0;
            end else begin
                if (r || w) begin
                    acc++;
                    n_chk++;
                    if (r !== !wr || w !== wr) begin
                        n_fail++; $display("FAIL strobe: got r=%b w=%b expected write=%b", r, w, wr);
                    end
                    n_chk++;
                    if (address_bus !== 16'(addr_e)) begin
                        n_fail++; $display("FAIL address: got %h expected %h", address_bus, 16'(addr_e));
                    end
                    if (wr) begin
                        n_chk++;
                        if (data_out !== val) begin
                            n_fail++; $display("FAIL data_out: got %h expected %h", data_out, val);
                        end
                        if (acc > nwait) mem[address_bus] = data_out;
                    end
                end
                bus_ready = (acc > nwait);
                sp_load   = noise && (r || w);
                sp_in     = 16'($urandom);
            end
        end
        n_chk++;
        if (!seen) begin
            n_fail++; $display("FAIL done_timeout: got no done expected done within 40 cycles");
        end
        n_chk++;
        if (n != (fe ? 1 : nwait + 2)) begin
            n_fail++; $display("FAIL done_latency: got %0d expected %0d", n, fe ? 1 : nwait + 2);
        end
        n_chk++;
        if (acc != (fe ? 0 : nwait + 1)) begin
            n_fail++; $display("FAIL access_cycles: got %0d expected %0d", acc, fe ? 0 : nwait + 1);
        end
        if (!fe) begin
            if (wr) begin
                exp_mem[sp_m] = val;
                if (o == 2'b10) exp_pc = tgt;
                sp_m = (sp_m + 65535) % 65536;
            end else begin
                rv = exp_mem[(sp_m + 1) % 65536];
                if (o == 2'b01) exp_pop = rv;
                else exp_pc = rv;
                sp_m = (sp_m + 1) % 65536;
            end
        end
        n_chk++;
        if (fault !== fe) begin
            n_fail++; $display("FAIL fault: got %b expected %b", fault, fe);
        end
        n_chk++;
        if (pc_load !== (!fe && o[1])) begin
            n_fail++; $display("FAIL pc_load: got %b expected %b", pc_load, !fe && o[1]);
        end
        n_chk++;
        if (pop_data !== exp_pop) begin
            n_fail++; $display("FAIL pop_data: got %h expected %h", pop_data, exp_pop);
        end
        n_chk++;
        if (pc_out !== exp_pc) begin
            n_fail++; $display("FAIL pc_out: got %h expected %h", pc_out, exp_pc);
        end
        n_chk++;
        if (sp !== 16'(sp_m)) begin
            n_fail++; $display("FAIL sp: got %h expected %h", sp, 16'(sp_m));
        end
        if (wr && !fe) begin
            n_chk++;
            if (mem[addr_e] !== val) begin
                n_fail++; $display("FAIL mem_write: got %h expected %h", mem[addr_e], val);
            end
        end
        @(negedge clk);
        n_chk++;
        if (done !== 1'b0 || op_ready !== 1'b1) begin
            n_fail++; $display("FAIL done_pulse: got done=%b op_ready=%b expected 0/1", done, op_ready);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        op_valid = 1'b0; sp_load = 1'b0; bus_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sp_m = SP_RESET; exp_pop = '0; exp_pc = '0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_chk++;
        if (sp !== 16'h07FF || r !== 1'b0 || w !== 1'b0 || done !== 1'b0 || fault !== 1'b0 || pc_load !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got sp=%h r=%b w=%b done=%b fault=%b pc_load=%b expected 07ff/0/0/0/0/0",
                               sp, r, w, done, fault, pc_load);
        end
        n_chk++;
        if (pop_data !== 16'h0 || pc_out !== 16'h0 || data_out !== 16'h0 || address_bus !== 16'h0) begin
            n_fail++; $display("FAIL reset_data: got pop=%h pc=%h dout=%h addr=%h expected all 0",
                               pop_data, pc_out, data_out, address_bus);
        end
        n_chk++;
        if (op_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 1", op_ready);
        end
    endtask

    task automatic test_push_pop();
        apply_reset();
        run_op(2'b00, 16'hBEEF, 16'h0, 0, 1'b0);
        run_op(2'b01, 16'h0, 16'h0, 3, 1'b0);
    endtask

    task automatic test_call_ret();
        apply_reset();
        run_op(2'b10, 16'h0123, 16'h4000, 0, 1'b0);
        run_op(2'b11, 16'h0, 16'h0, 1, 1'b0);
    endtask

    task automatic test_reset_mid_access();
        apply_reset();
        run_op(2'b00, 16'h5A5A, 16'h0, 0, 1'b0);
        @(negedge clk);
        op_valid = 1'b1; op = 2'b01; bus_ready = 1'b0;
        @(posedge clk);
        #1 op_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if (r !== 1'b1) begin
            n_fail++; $display("FAIL mid_wait_read: got r=%b expected 1", r);
        end
        reset = 1'b1;
        #1;
        n_chk++;
        if (r !== 1'b0 || w !== 1'b0 || sp !== 16'h07FF) begin
            n_fail++; $display("FAIL async_reset: got r=%b w=%b sp=%h expected 0/0/07ff", r, w, sp);
        end
        @(negedge clk);
        reset = 1'b0;
        bus_ready = 1'b1;
        sp_m = SP_RESET;
        @(negedge clk);
        n_chk++;
        if (op_ready !== 1'b1 || sp !== 16'h07FF) begin
            n_fail++; $display("FAIL post_reset_ready: got op_ready=%b sp=%h expected 1/07ff", op_ready, sp);
        end
    endtask

    task automatic test_sp_load();
        apply_reset();
        @(negedge clk);
        sp_load = 1'b1; sp_in = 16'h0750;
        op_valid = 1'b1; op = 2'b00; push_data = 16'h1234; bus_ready = 1'b1;
        #1;
        n_chk++;
        if (op_ready !== 1'b0) begin
            n_fail++; $display("FAIL sp_load_ready: got %b expected 0", op_ready);
        end
        @(posedge clk);
        #1;
        sp_load = 1'b0;
        n_chk++;
        if (sp !== 16'h0750 || r !== 1'b0 || w !== 1'b0) begin
            n_fail++; $display("FAIL sp_load_value: got sp=%h r=%b w=%b expected 0750/0/0", sp, r, w);
        end
        sp_m = 'h0750;
        run_op(2'b00, 16'h1234, 16'h0, 0, 1'b0);
        run_op(2'b01, 16'h0, 16'h0, 2, 1'b1);
    endtask

`ifdef STACK_UNIT_BOUNDS_EN
    task automatic test_bounds();
        apply_reset();
        run_op(2'b01, 16'h0, 16'h0, 0, 1'b0);
        run_op(2'b11, 16'h0, 16'h0, 0, 1'b0);
        for (int i = 0; i < 256; i++) run_op(2'b00, 16'($urandom), 16'h0, 0, 1'b0);
        run_op(2'b00, 16'hDEAD, 16'h0, 0, 1'b0);
        run_op(2'b10, 16'h0777, 16'h2222, 0, 1'b0);
        n_chk++;
        if (mem[SP_LIMIT - 1] === 16'hDEAD) begin
            n_fail++; $display("FAIL full_no_write: got %h expected not dead", mem[SP_LIMIT - 1]);
        end
    endtask
`else
    task automatic test_wrap();
        apply_reset();
        run_op(2'b01, 16'h0, 16'h0, 0, 1'b0);
        run_op(2'b00, 16'hC0DE, 16'h0, 1, 1'b0);
        run_op(2'b00, 16'h7777, 16'h0, 0, 1'b0);
        run_op(2'b01, 16'h0, 16'h0, 0, 1'b0);
    endtask
`endif

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 80; i++) begin
            run_op(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
                   int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i] = '0;
            exp_mem[i] = '0;
        end
        sp_m = SP_RESET; exp_pop = '0; exp_pc = '0;
        test_reset();
        test_push_pop();
        test_call_ret();
        test_reset_mid_access();
        test_sp_load();
`ifdef STACK_UNIT_BOUNDS_EN
        test_bounds();
`else
        test_wrap();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
